// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - direct-mapped instruction cache with multi-word line refill
//
// Serves fetch hits combinationally. On a miss it stalls the fetch stage and
// fills the whole line from backing memory, one word per mem_ack.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   RESET      synchronous, active-high reset
//   pc         fetch byte address (pc[1:0] ignored)
//   rd_en      fetch request this cycle
//   inval      single-cycle pulse, invalidates the whole cache
//   instr      instruction for pc, NOP (32'h0000_0013) whenever stall=1
//   stall      instr not valid this cycle; hold PC and IF/DEC register
//   mem_req    backing-memory word read request
//   mem_addr   word-aligned backing-memory address (0 when not filling)
//   mem_ack    mem_rdata is valid for mem_addr this cycle
//   mem_rdata  returned memory word
//   miss_cnt   saturating count of refills started
module icache_refill_ctrl #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [31:0] pc,
    input  logic        rd_en,
    input  logic        inval,
    output logic [31:0] instr,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] miss_cnt
);

    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = 32 - IB - OB - 2;
    localparam logic [OB-1:0] LAST_WORD = OB'(LINE_WORDS - 1);
    localparam logic [31:0]   NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [OB-1:0]   cnt_q, cnt_d;
    logic [TB-1:0]   ltag_q, ltag_d;
    logic [IB-1:0]   lidx_q, lidx_d;
    logic [15:0]     miss_cnt_q, miss_cnt_d;
    logic            pend_inval_q, pend_inval_d;

    logic [TB-1:0]   tag_arr_q [LINES];
    logic [31:0]     data_q    [LINES*LINE_WORDS];
    logic            data_we;
    logic            tag_we;

    logic [OB-1:0]   off;
    logic [IB-1:0]   idx;
    logic [TB-1:0]   tag;
    logic            hit;
    logic            pc_unused;

    assign off       = pc[OB+1:2];
    assign idx       = pc[IB+OB+1:OB+2];
    assign tag       = pc[31:IB+OB+2];
    assign pc_unused = ^pc[1:0];
    assign hit       = rd_en & valid_q[idx] & (tag_arr_q[idx] == tag);
    assign miss_cnt  = miss_cnt_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        ltag_d       = ltag_q;
        lidx_d       = lidx_q;
        miss_cnt_d   = miss_cnt_q;
        pend_inval_d = pend_inval_q;
        stall        = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = 32'h0;
        instr        = NOP;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Invalidation takes a whole cycle of its own so a lookup
                // never races with the clear of the valid bits.
                if (inval || pend_inval_q) begin
                    stall        = 1'b1;
                    valid_d      = '0;
                    pend_inval_d = 1'b0;
                end else if (rd_en) begin
                    if (hit) begin
                        instr = data_q[{idx, off}];
                    end else begin
                        stall   = 1'b1;
                        ltag_d  = tag;
                        lidx_d  = idx;
                        cnt_d   = '0;
                        state_d = S_FILL;
                        if (miss_cnt_q != 16'hFFFF) begin
                            miss_cnt_d = miss_cnt_q + 16'd1;
                        end
                    end
                end
            end
            S_FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {ltag_q, lidx_q, cnt_q, 2'b00};
                if (inval) begin
                    pend_inval_d = 1'b1;
                end
                if (mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OB'(1);
                    if (cnt_q == LAST_WORD) begin
                        valid_d[lidx_q] = 1'b1;
                        tag_we          = 1'b1;
                        state_d         = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // One settling cycle; the next IDLE cycle re-looks-up pc.
                stall   = 1'b1;
                state_d = S_IDLE;
                if (inval) begin
                    pend_inval_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            cnt_q        <= '0;
            ltag_q       <= '0;
            lidx_q       <= '0;
            miss_cnt_q   <= 16'h0;
            pend_inval_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            ltag_q       <= ltag_d;
            lidx_q       <= lidx_d;
            miss_cnt_q   <= miss_cnt_d;
            pend_inval_q <= pend_inval_d;
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (!RESET && data_we) begin
            data_q[{lidx_q, cnt_q}] <= mem_rdata;
        end
        if (!RESET && tag_we) begin
            tag_arr_q[lidx_q] <= ltag_q;
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - scoreboard bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int K_STALL  = 0;
    localparam int K_MEMREQ = 1;
    localparam int K_MADDR  = 2;
    localparam int K_MISS   = 3;
    localparam int K_INSTR  = 4;
    localparam int K_HITS   = 5;
    localparam int K_ADDRQ  = 6;
    localparam int K_FETCHQ = 7;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        rd_en = 1'b0;
    logic        inval = 1'b0;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [15:0] miss_cnt;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk       (clk),
        .RESET     (RESET),
        .pc        (pc),
        .rd_en     (rd_en),
        .inval     (inval),
        .instr     (instr),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .miss_cnt  (miss_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        int          stalls;
        logic [15:0] miss;
    } fetch_exp_t;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } probe_t;

    fetch_exp_t  exp_fetch[$];
    logic [31:0] exp_addr[$];
    probe_t      probes[$];

    int vectors     = 0;
    int miscompares = 0;
    int stall_run   = 0;
    int hits_seen   = 0;
    int ack_mode    = 0;
    logic req_prev  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: mode 0 acks one cycle after each request, mode 1 holds ack high.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ack_mode == 1) mem_ack = 1'b1;
            else mem_ack = mem_req && req_prev && !mem_ack;
            req_prev  = mem_req;
            mem_rdata = mem_word(mem_addr);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a beat or a fetch.
    initial begin
        forever begin
            @(negedge clk);
            if (RESET) begin
                stall_run = 0;
            end else begin
                if (mem_req && mem_ack) begin
                    if (exp_addr.size() == 0) begin
                        chk("unexpected_mem_beat", {31'h0, mem_req}, 32'h0);
                    end else begin
                        chk("mem_addr", mem_addr, exp_addr.pop_front());
                    end
                end
                if (rd_en && stall) stall_run++;
                if (rd_en && !stall) begin
                    hits_seen++;
                    if (exp_fetch.size() == 0) begin
                        chk("unexpected_fetch", {31'h0, stall}, 32'h1);
                    end else begin
                        fetch_exp_t e;
                        e = exp_fetch.pop_front();
                        chk("instr", instr, e.instr);
                        chk("stall_cycles", stall_run, e.stalls);
                        chk("miss_cnt", {16'h0, miss_cnt}, {16'h0, e.miss});
                    end
                    stall_run = 0;
                end
            end
            while (probes.size() > 0) begin
                probe_t p;
                p = probes.pop_front();
                case (p.kind)
                    K_STALL:  chk("stall", {31'h0, stall}, p.val);
                    K_MEMREQ: chk("mem_req", {31'h0, mem_req}, p.val);
                    K_MADDR:  chk("mem_addr_idle", mem_addr, p.val);
                    K_MISS:   chk("miss_cnt_probe", {16'h0, miss_cnt}, p.val);
                    K_INSTR:  chk("instr_probe", instr, p.val);
                    K_HITS:   chk("fetch_timeout", hits_seen, p.val);
                    K_ADDRQ:  chk("addr_queue_left", exp_addr.size(), p.val);
                    default:  chk("fetch_queue_left", exp_fetch.size(), p.val);
                endcase
            end
        end
    end

    task automatic probe(input int kind, input logic [31:0] val);
        probe_t p;
        p.kind = kind;
        p.val  = val;
        probes.push_back(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch: queue the expected refill beats and the final instruction,
    // hold rd_en until the monitor reports the fetch, optionally pulsing inval.
    task automatic issue(input logic [31:0] a, input int refills, input int stalls,
                         input logic [15:0] exp_miss, input int inval_at);
        fetch_exp_t e;
        int start;
        bit done;
        for (int r = 0; r < refills; r++) begin
            for (int w = 0; w < 4; w++) begin
                exp_addr.push_back({a[31:4], 4'h0} + 32'(4 * w));
            end
        end
        e.instr  = mem_word({a[31:2], 2'b00});
        e.stalls = stalls;
        e.miss   = exp_miss;
        exp_fetch.push_back(e);
        start = hits_seen;
        done  = 1'b0;
        pc    = a;
        rd_en = 1'b1;
        for (int c = 1; c <= 80 && !done; c++) begin
            @(posedge clk);
            if (hits_seen != start) done = 1'b1;
            #1;
            inval = (c == inval_at);
        end
        rd_en = 1'b0;
        inval = 1'b0;
        if (!done) probe(K_HITS, 32'(start + 1));
    endtask

    initial begin
        RESET = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        RESET = 1'b0;
        probe(K_STALL, 32'h0);
        probe(K_MEMREQ, 32'h0);
        probe(K_MADDR, 32'h0);
        probe(K_MISS, 32'h0);
        probe(K_INSTR, NOP);
        tick();

        ack_mode = 0;
        issue(32'h0000_0000, 1, 10, 16'd1, 0);
        issue(32'h0000_0008, 0, 0, 16'd1, 0);

        ack_mode = 1;
        issue(32'h0000_0040, 1, 6, 16'd2, 0);
        ack_mode = 0;

        issue(32'h0000_0100, 1, 10, 16'd3, 0);
        issue(32'h0000_0104, 0, 0, 16'd3, 0);
        issue(32'h0000_0000, 1, 10, 16'd4, 0);
        issue(32'h0000_010C, 1, 10, 16'd5, 0);
        issue(32'h0000_0044, 0, 0, 16'd5, 0);

        // inval mid-fill: fill finishes, one clearing cycle, then a second refill.
        issue(32'h0000_0080, 2, 21, 16'd7, 3);
        issue(32'h0000_0084, 0, 0, 16'd7, 0);

        // RESET after two acknowledged words of a fill.
        exp_addr.push_back(32'h0000_0000);
        exp_addr.push_back(32'h0000_0004);
        pc    = 32'h0000_0000;
        rd_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        RESET = 1'b1;
        rd_en = 1'b0;
        tick();
        RESET = 1'b0;
        probe(K_MEMREQ, 32'h0);
        probe(K_STALL, 32'h0);
        probe(K_MISS, 32'h0);
        probe(K_ADDRQ, 32'h0);
        tick();
        issue(32'h0000_0000, 1, 10, 16'd1, 0);

        probe(K_ADDRQ, 32'h0);
        probe(K_FETCHQ, 32'h0);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
